// File: rtl/hazard_pipe_track.sv
// hazard_pipe_track
// Tracks the destination register, write-enable and load flag of the
// instructions in the EX and MEM stages for the forwarding unit. It also
// detects load-use hazards against the instruction in ID and requests a
// single-cycle stall. Stalls and branch flushes insert a bubble into EX.
// A saturating counter tallies the stall bubbles that have been inserted.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   id_*                fields of the instruction currently in ID
//   flush               branch taken in EX, kill the ID instruction
//   stall_out           hold PC and IF/ID this cycle (combinational)
//   dest_ex/regwr_ex/memrd_ex   EX-stage slot
//   dest_mem/regwr_mem          MEM-stage slot
//   bubble_count        saturating count of stall bubbles
module hazard_pipe_track #(
  parameter int REG_W    = 4,
  parameter int ZERO_REG = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwr,
  input  logic             id_memrd,
  input  logic [REG_W-1:0] id_addr_a,
  input  logic [REG_W-1:0] id_addr_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             flush,
  output logic             stall_out,
  output logic [REG_W-1:0] dest_ex,
  output logic             regwr_ex,
  output logic             memrd_ex,
  output logic [REG_W-1:0] dest_mem,
  output logic             regwr_mem,
  output logic [CNT_W-1:0] bubble_count
);

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             regwr;
    logic             memrd;
  } slot_t;

  localparam slot_t BUBBLE = '{dest: '0, regwr: 1'b0, memrd: 1'b0};

  slot_t            ex_q, ex_d;
  logic [REG_W-1:0] dest_mem_q;
  logic             regwr_mem_q;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  logic             zero_dest;
  logic             load_use;

  // Writes to the hard-wired zero register carry no data worth forwarding,
  // so both the write-enable and the load flag are dropped on entry to EX.
  assign zero_dest = (id_dest == REG_W'(ZERO_REG));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    load_use  = 1'b0;
    stall_out = 1'b0;
    ex_d      = BUBBLE;
    bubble_d  = bubble_q;

    load_use = ex_q.memrd & ex_q.regwr & id_valid &
               ((id_use_a & (id_addr_a == ex_q.dest)) |
                (id_use_b & (id_addr_b == ex_q.dest)));

    // Reset must silence the stall request in the same cycle it is applied.
    stall_out = load_use & ~flush & ~reset;

    if (flush || stall_out) begin
      ex_d = BUBBLE;
    end else if (id_valid) begin
      ex_d.dest  = id_dest;
      ex_d.regwr = id_regwr & ~zero_dest;
      ex_d.memrd = id_memrd & ~zero_dest;
    end

    if (stall_out && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values (MEM must capture the old EX contents).
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= BUBBLE;
      dest_mem_q  <= '0;
      regwr_mem_q <= 1'b0;
      bubble_q    <= '0;
    end else begin
      ex_q        <= ex_d;
      // MEM never stalls or flushes; it always takes the old EX slot.
      dest_mem_q  <= ex_q.dest;
      regwr_mem_q <= ex_q.regwr;
      bubble_q    <= bubble_d;
    end
  end

  assign dest_ex      = ex_q.dest;
  assign regwr_ex     = ex_q.regwr;
  assign memrd_ex     = ex_q.memrd;
  assign dest_mem     = dest_mem_q;
  assign regwr_mem    = regwr_mem_q;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_hazard_pipe_track.sv
// Self-checking bench for hazard_pipe_track: a behavioural pipeline model
// compared against the DUT every cycle, plus directed literal expectations.
module tb_hazard_pipe_track;

  localparam int REG_W = 4;
  localparam int CNT_W = 8;
  localparam int ZREG  = 15;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_dest = '0;
  logic             id_regwr = 1'b0;
  logic             id_memrd = 1'b0;
  logic [REG_W-1:0] id_addr_a = '0;
  logic [REG_W-1:0] id_addr_b = '0;
  logic             id_use_a = 1'b0;
  logic             id_use_b = 1'b0;
  logic             flush = 1'b0;
  logic             stall_out;
  logic [REG_W-1:0] dest_ex;
  logic             regwr_ex;
  logic             memrd_ex;
  logic [REG_W-1:0] dest_mem;
  logic             regwr_mem;
  logic [CNT_W-1:0] bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_pipe_track #(.REG_W(REG_W), .ZERO_REG(ZREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_dest(id_dest), .id_regwr(id_regwr),
    .id_memrd(id_memrd), .id_addr_a(id_addr_a), .id_addr_b(id_addr_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .flush(flush),
    .stall_out(stall_out), .dest_ex(dest_ex), .regwr_ex(regwr_ex),
    .memrd_ex(memrd_ex), .dest_mem(dest_mem), .regwr_mem(regwr_mem),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pipe[0] is the instruction in EX, pipe[1] the one in MEM; a bubble is
  // simply an instruction that writes nothing.
  typedef struct {
    int dest;
    bit wr;
    bit ld;
  } instr_t;

  instr_t pipe [2];
  int     m_count = 0;

  function automatic bit model_stall();
    bit reads_ld;
    reads_ld = (id_use_a && int'(id_addr_a) == pipe[0].dest) ||
               (id_use_b && int'(id_addr_b) == pipe[0].dest);
    return !reset && !flush && id_valid && pipe[0].ld && pipe[0].wr && reads_ld;
  endfunction

  always @(posedge clk) begin
    instr_t nxt;
    bit     st;
    st = model_stall();
    if (reset) begin
      pipe[0] = '{0, 0, 0};
      pipe[1] = '{0, 0, 0};
      m_count = 0;
    end else begin
      if (flush || st || !id_valid) nxt = '{0, 0, 0};
      else if (int'(id_dest) == ZREG) nxt = '{ZREG, 0, 0};
      else nxt = '{int'(id_dest), id_regwr, id_memrd};
      pipe[1] = pipe[0];
      pipe[0] = nxt;
      if (st && m_count < CMAX) m_count = m_count + 1;
    end
  end

  // Compare process: outputs are sampled on the falling edge, far from the
  // rising edge where inputs and state change.
  always @(negedge clk) begin
    check("m_stall",     32'(stall_out),    32'(model_stall()));
    check("m_dest_ex",   32'(dest_ex),      32'(pipe[0].dest));
    check("m_regwr_ex",  32'(regwr_ex),     32'(pipe[0].wr));
    check("m_memrd_ex",  32'(memrd_ex),     32'(pipe[0].ld));
    check("m_dest_mem",  32'(dest_mem),     32'(pipe[1].dest));
    check("m_regwr_mem", 32'(regwr_mem),    32'(pipe[1].wr));
    check("m_count",     32'(bubble_count), 32'(m_count));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int d, input bit wr, input bit ld,
                        input int a, input bit ua, input int b, input bit ub);
    id_valid  = v;
    id_dest   = REG_W'(d);
    id_regwr  = wr;
    id_memrd  = ld;
    id_addr_a = REG_W'(a);
    id_use_a  = ua;
    id_addr_b = REG_W'(b);
    id_use_b  = ub;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with random ID inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_id($urandom_range(1), $urandom_range(15), $urandom_range(1),
             $urandom_range(1), $urandom_range(15), $urandom_range(1),
             $urandom_range(15), $urandom_range(1));
      tick();
    end
    #1;
    check("rst_stall", 32'(stall_out), 0);
    check("rst_dest_ex", 32'(dest_ex), 0);
    check("rst_memrd_ex", 32'(memrd_ex), 0);
    check("rst_dest_mem", 32'(dest_mem), 0);
    check("rst_count", 32'(bubble_count), 0);
    reset = 1'b0;

    // Simple ALU write to R3: EX after one cycle, MEM after two
    set_id(1, 3, 1, 0, 0, 0, 0, 0);
    tick();
    check("lat_dest_ex", 32'(dest_ex), 3);
    check("lat_regwr_ex", 32'(regwr_ex), 1);
    idle();
    tick();
    check("lat_dest_mem", 32'(dest_mem), 3);
    check("lat_regwr_mem", 32'(regwr_mem), 1);

    // Load-use on source A
    set_id(1, 5, 1, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 6, 1, 0, 5, 1, 0, 0);
    #1 check("lu_stall", 32'(stall_out), 1);
    tick();
    check("lu_regwr_ex", 32'(regwr_ex), 0);
    check("lu_dest_mem", 32'(dest_mem), 5);
    check("lu_regwr_mem", 32'(regwr_mem), 1);
    check("lu_count", 32'(bubble_count), 1);
    #1 check("lu_release", 32'(stall_out), 0);
    tick();
    check("lu_proceed_dest", 32'(dest_ex), 6);
    check("lu_proceed_wr", 32'(regwr_ex), 1);

    // No false stall: unused source B, then a non-load writer of R5
    set_id(1, 5, 1, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 2, 1, 0, 0, 0, 5, 0);
    #1 check("nf_use_b0", 32'(stall_out), 0);
    tick();
    set_id(1, 5, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 8, 1, 0, 5, 1, 5, 1);
    #1 check("nf_alu", 32'(stall_out), 0);
    tick();
    check("nf_count", 32'(bubble_count), 1);

    // Zero register squash
    set_id(1, ZREG, 1, 1, 0, 0, 0, 0);
    tick();
    check("zr_regwr", 32'(regwr_ex), 0);
    check("zr_memrd", 32'(memrd_ex), 0);
    set_id(1, 4, 1, 0, ZREG, 1, 0, 0);
    #1 check("zr_stall", 32'(stall_out), 0);
    tick();

    // Flush wins over stall
    set_id(1, 7, 1, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 9, 1, 0, 7, 1, 0, 0);
    flush = 1'b1;
    #1 check("fl_stall", 32'(stall_out), 0);
    tick();
    flush = 1'b0;
    check("fl_regwr_ex", 32'(regwr_ex), 0);
    check("fl_dest_mem", 32'(dest_mem), 7);
    check("fl_count", 32'(bubble_count), 1);
    idle();
    tick();

    // Reset during a stall
    set_id(1, 4, 1, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 1, 1, 0, 0, 0, 4, 1);
    #1 check("rs_stall_pre", 32'(stall_out), 1);
    reset = 1'b1;
    #1 check("rs_stall_drop", 32'(stall_out), 0);
    tick();
    check("rs_dest_ex", 32'(dest_ex), 0);
    check("rs_count", 32'(bubble_count), 0);
    reset = 1'b0;
    idle();
    tick();

    // Saturation: a load that reads its own destination stalls every other
    // cycle while held; 530 cycles give 265 stalls.
    set_id(1, 5, 1, 1, 5, 1, 0, 0);
    for (int i = 0; i < 530; i++) tick();
    check("sat_255", 32'(bubble_count), 255);
    for (int i = 0; i < 6; i++) tick();
    check("sat_hold", 32'(bubble_count), 255);
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hazard_pipe_track.md
# hazard_pipe_track

Pipeline-state tracker between decode (ID) and the forwarding unit. It registers the destination register, write-enable and load flag of the instructions in the EX and MEM stages, and supplies those registered values to the forwarding unit. It also detects load-use hazards, asserts a one-cycle stall to the fetch/decode front end, and inserts bubbles on stalls and branch flushes. A saturating counter records inserted stall bubbles for performance monitoring.

## Interface
- REG_W, 4: register-address width.
- ZERO_REG, 15: hard-wired zero register; writes to it are never tracked.
- CNT_W, 8: bubble counter width.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_dest  in  REG_W  destination register (Rd) of the ID instruction.
- id_regwr  in  1  ID instruction writes the register file.
- id_memrd  in  1  ID instruction is a load.
- id_addr_a  in  REG_W  source A (Rn) of the ID instruction.
- id_addr_b  in  REG_W  source B (Rm) of the ID instruction.
- id_use_a  in  1  ID instruction actually reads source A.
- id_use_b  in  1  ID instruction actually reads source B.
- flush  in  1  branch taken in EX; the ID instruction is killed.
- stall_out  out  1  hold the PC and the IF/ID register this cycle.
- dest_ex  out  REG_W  Rd of the EX-stage instruction.
- regwr_ex  out  1  EX-stage instruction writes the register file.
- memrd_ex  out  1  EX-stage instruction is a load.
- dest_mem  out  REG_W  Rd of the MEM-stage instruction.
- regwr_mem  out  1  MEM-stage instruction writes the register file.
- bubble_count  out  CNT_W  number of stall bubbles inserted; saturating.

## Operation
- EX slot registers: dest_ex, regwr_ex, memrd_ex. MEM slot registers: dest_mem, regwr_mem.
- Write squash: an incoming regwr is forced to 0 when id_dest == ZERO_REG. In that case memrd_ex is also forced to 0.
- load_use (combinational) = memrd_ex & regwr_ex & id_valid & ((id_use_a & id_addr_a == dest_ex) | (id_use_b & id_addr_b == dest_ex)).
- stall_out = load_use & ~flush.
- Per-cycle update, with priority reset > flush > stall > normal:
  - reset: every output register is cleared to 0. This includes all dest, regwr and memrd registers and bubble_count. stall_out evaluates to 0.
  - flush: the EX slot takes a bubble (dest 0, regwr 0, memrd 0). MEM takes the old EX contents. bubble_count is unchanged.
  - stall (stall_out=1): the EX slot takes a bubble and MEM takes the old EX contents. bubble_count increments by 1, saturating at 2^CNT_W-1. The ID inputs are expected to be held by upstream on the following cycle.
  - normal: EX takes the ID fields if id_valid, otherwise a bubble. MEM takes the old EX contents.
- The MEM stage never stalls and never flushes; it always advances.
- Stall length is at most one cycle per load: once the load has moved to MEM, memrd_ex=0 and the forwarding unit supplies the value from MEM.
- Back-to-back loads each cause their own independent single-cycle stall.

## Timing
- Registered outputs reflect ID inputs with 1-cycle latency (ID→EX), and 2 cycles (ID→MEM) for dest_mem/regwr_mem.
- stall_out is combinational from the current EX registers and the ID inputs. It is valid within the same cycle and has no registered delay.
- flush and stall occurring in the same cycle: flush wins. stall_out=0 and the counter does not increment.
- Reset asserted mid-stall: the next edge clears everything. stall_out drops in the reset cycle regardless of the inputs.
- Counter saturation: at 255 with a stall, it stays at 255 and does not wrap.

## Test plan
- Reset: hold reset 2 cycles with random ID inputs -> all outputs 0. After release, ID {dest=3, regwr=1, valid=1} -> dest_ex=3, regwr_ex=1 next cycle; dest_mem=3, regwr_mem=1 the cycle after.
- Load-use on A: load to R5 enters EX; ID presents addr_a=5, use_a=1 -> stall_out=1 that cycle. Next edge: EX bubble (regwr_ex=0), dest_mem=5, regwr_mem=1, bubble_count=1. The held ID instruction then proceeds with stall_out=0.
- No false stall: load to R5 in EX; ID addr_b=5 with use_b=0, or a non-load ALU write to R5 -> stall_out=0 and the counter is unchanged.
- ZERO_REG squash: load with id_dest=15 -> regwr_ex=0, memrd_ex=0. A following instruction with addr_a=15 -> stall_out=0.
- Flush vs. stall: load to R7 in EX; ID reads R7; flush=1 in the same cycle -> stall_out=0, EX bubble, dest_mem=7, bubble_count unchanged.
- Saturation: force 260 consecutive load-use stalls -> bubble_count reaches 255 and holds there.
